seq_shift_add_multiplier: RTL

//  Sequential unsigned WIDTH x WIDTH multiplier built around a WIDTH-bit ripple-carry adder (full-adder chain).
//  It sits directly downstream of the operand source and drives the ripple-carry adder once per cycle.
//  It uses shift-and-add: one multiplier bit per clock, giving a 2*WIDTH-bit product.

---
 rtl/seq_shift_add_multiplier.sv | 104 ++++++++++
 1 files changed

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
// Each CALC cycle adds through a WIDTH-bit ripple-carry adder and retires one multiplier bit.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic                 busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] p;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] p_next;

    // Full-adder chain with carry-in 0; the MSB of the result is the carry-out.
    function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   c;
        logic [WIDTH-1:0] s;
        c[0] = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        return {c[WIDTH], s};
    endfunction

    always_comb begin
        addend = p[0] ? mcand : '0;
        sum    = ripple_add(p[2*WIDTH-1:WIDTH], addend);
        p_next = {sum, p[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            out_product <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= in_a;
                        p        <= {{WIDTH{1'b0}}, in_b};
                        count    <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    p     <= p_next;
                    count <= count + 1'b1;
                    // Publish the final partial product on the same edge that finishes it.
                    if (count == LAST) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        out_product <= p_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        out_product <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
